// File: rtl/alu_op_sequencer.sv
// Command FIFO + settle/capture sequencer in front of the combinational 16-bit ALU breadboard.
// Optional result chaining (previous result as operand A) is built when ALU_SEQ_CHAIN_EN is defined.
module alu_op_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [15:0] CmdA,
    input  logic [15:0] CmdB,
    input  logic [3:0]  CmdOp,
    input  logic        CmdChain,
    output logic [15:0] AluA,
    output logic [15:0] AluB,
    output logic [3:0]  AluOp,
    input  logic [31:0] AluResult,
    input  logic [1:0]  AluError,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspResult,
    output logic [1:0]  RspError,
    output logic [3:0]  RspOp,
    output logic        Busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [15:0]   mem_a  [FIFO_DEPTH];
    logic [15:0]   mem_b  [FIFO_DEPTH];
    logic [3:0]    mem_op [FIFO_DEPTH];
    logic          empty, full, push, pop, capture, legal;
    logic [15:0]   next_a;
    logic [31:0]   cap_result;
    logic [1:0]    cap_error;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign CmdReady = !full;
    assign push     = CmdValid && !full;
    assign pop      = !empty && ((state == IDLE) || (state == RESP && RspReady));
    assign capture  = (state == EXEC) && (cnt == CW'(1));
    assign Busy     = (state != IDLE) || !empty;

    assign legal      = (AluOp >= 4'h4) && (AluOp <= 4'h8);
    assign cap_result = legal ? AluResult : 32'd0;
    assign cap_error  = legal ? AluError : 2'b11;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr[AW-1:0]]  <= CmdA;
            mem_b[wr_ptr[AW-1:0]]  <= CmdB;
            mem_op[wr_ptr[AW-1:0]] <= CmdOp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

`ifdef ALU_SEQ_CHAIN_EN
    logic        mem_chain [FIFO_DEPTH];
    logic [15:0] chain_val;
    logic        chain_vld;

    always_ff @(posedge clk) begin
        if (push) mem_chain[wr_ptr[AW-1:0]] <= CmdChain;
    end

    // Only error-free results are eligible to feed the next chained command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_val <= '0;
            chain_vld <= 1'b0;
        end else if (capture) begin
            chain_vld <= (cap_error == 2'b00);
            if (cap_error == 2'b00) chain_val <= AluResult[15:0];
        end
    end

    assign next_a = (mem_chain[rd_ptr[AW-1:0]] && chain_vld) ? chain_val : mem_a[rd_ptr[AW-1:0]];
`else
    logic unused_chain;
    assign unused_chain = CmdChain;
    assign next_a       = mem_a[rd_ptr[AW-1:0]];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            AluA      <= '0;
            AluB      <= '0;
            AluOp     <= '0;
            RspValid  <= 1'b0;
            RspResult <= '0;
            RspError  <= '0;
            RspOp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        AluA  <= next_a;
                        AluB  <= mem_b[rd_ptr[AW-1:0]];
                        AluOp <= mem_op[rd_ptr[AW-1:0]];
                        cnt   <= CW'(SETTLE_CYCLES);
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (capture) begin
                        RspResult <= cap_result;
                        RspError  <= cap_error;
                        RspOp     <= AluOp;
                        RspValid  <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        if (pop) begin
                            AluA  <= next_a;
                            AluB  <= mem_b[rd_ptr[AW-1:0]];
                            AluOp <= mem_op[rd_ptr[AW-1:0]];
                            cnt   <= CW'(SETTLE_CYCLES);
                            state <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the ALU breadboard.
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        CmdValid, CmdReady, CmdChain;
    logic [15:0] CmdA, CmdB, AluA, AluB;
    logic [3:0]  CmdOp, AluOp, RspOp;
    logic [31:0] AluResult, RspResult;
    logic [1:0]  AluError, RspError;
    logic        RspValid, RspReady, Busy;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdA(CmdA), .CmdB(CmdB),
        .CmdOp(CmdOp), .CmdChain(CmdChain),
        .AluA(AluA), .AluB(AluB), .AluOp(AluOp),
        .AluResult(AluResult), .AluError(AluError),
        .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult),
        .RspError(RspError), .RspOp(RspOp), .Busy(Busy)
    );

    // Breadboard model; illegal opcodes return junk so the sequencer must mask it.
    always_comb begin
        AluResult = 32'd0;
        AluError  = 2'b00;
        case (AluOp)
            4'h4: AluResult = {16'd0, AluA} + {16'd0, AluB};
            4'h5: AluResult = {16'd0, AluA} - {16'd0, AluB};
            4'h6: AluResult = {16'd0, AluA} * {16'd0, AluB};
            4'h7: if (AluB == 16'd0) AluError = 2'b10; else AluResult = {16'd0, AluA / AluB};
            4'h8: if (AluB == 16'd0) AluError = 2'b10; else AluResult = {16'd0, AluA % AluB};
            default: begin
                AluResult = 32'hDEADBEEF;
                AluError  = 2'b01;
            end
        endcase
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input logic ch, output bit acc);
        CmdA = a; CmdB = b; CmdOp = op; CmdChain = ch; CmdValid = 1'b1;
        acc = CmdReady;
        @(posedge clk); #1;
        CmdValid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output int n);
        n = 0;
        while (!RspValid && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; RspReady = 1'b0;
        CmdA = 16'd9; CmdB = 16'd9; CmdOp = 4'h4; CmdChain = 1'b0; CmdValid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (CmdReady !== 1'b1) begin errors++; $display("FAIL reset_cmdready got=%b exp=1", CmdReady); end
        checks++; if ({AluA, AluB, AluOp} !== 36'd0) begin errors++; $display("FAIL reset_alu got=%h exp=0", {AluA, AluB, AluOp}); end
        checks++; if ({RspValid, RspResult, RspError, RspOp} !== 39'd0) begin errors++; $display("FAIL reset_rsp got=%h exp=0", {RspValid, RspResult, RspError, RspOp}); end
        CmdValid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_push_ignored busy got=%b exp=0", Busy); end
    endtask

    task automatic test_add;
        bit acc; int n;
        RspReady = 1'b1;
        push(16'd100, 16'd150, 4'h4, 1'b0, acc);
        checks++; if (acc !== 1'b1 || Busy !== 1'b1) begin errors++; $display("FAIL add_accept got acc=%b busy=%b exp=1 1", acc, Busy); end
        @(posedge clk); #1;
        checks++; if ({AluA, AluB, AluOp} !== {16'd100, 16'd150, 4'h4}) begin errors++; $display("FAIL add_alu_load got=%h exp=%h", {AluA, AluB, AluOp}, {16'd100, 16'd150, 4'h4}); end
        checks++; if (RspValid !== 1'b0) begin errors++; $display("FAIL add_early_valid got=%b exp=0", RspValid); end
        wait_rsp(10, n);
        checks++; if (n !== 2 || RspValid !== 1'b1) begin errors++; $display("FAIL add_latency got=%0d exp=2", n); end
        checks++; if ({RspResult, RspError, RspOp} !== {32'd250, 2'b00, 4'h4}) begin errors++; $display("FAIL add_rsp got=%0d/%b/%h exp=250/00/4", RspResult, RspError, RspOp); end
        @(posedge clk); #1;
        checks++; if (RspValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL add_done got valid=%b busy=%b exp=0 0", RspValid, Busy); end
    endtask

    task automatic test_backpressure;
        bit acc; int n;
        RspReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(16'(10 * (i + 1)), 16'(i), 4'h4, 1'b0, acc);
            checks++; if (acc !== (i < 5)) begin errors++; $display("FAIL bp_accept_%0d got=%b exp=%b", i, acc, (i < 5)); end
        end
        checks++; if (CmdReady !== 1'b0) begin errors++; $display("FAIL bp_full got=%b exp=0", CmdReady); end
        wait_rsp(10, n);
        RspReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(10, n);
            checks++; if (k > 0 && n !== 2) begin errors++; $display("FAIL bp_spacing_%0d got=%0d exp=2", k, n); end
            checks++; if (RspValid !== 1'b1 || RspResult !== 32'(10 * (k + 1) + k)) begin errors++; $display("FAIL bp_order_%0d got=%0d exp=%0d", k, RspResult, 10 * (k + 1) + k); end
            @(posedge clk); #1;
            if (k == 0) begin
                checks++; if (CmdReady !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got=%b exp=1", CmdReady); end
            end
        end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL bp_drained busy got=%b exp=0", Busy); end
    endtask

    task automatic test_div_zero;
        bit acc; int n;
        RspReady = 1'b1;
        push(16'd21, 16'd0, 4'h7, 1'b0, acc);
        wait_rsp(10, n);
        checks++; if (n !== 3 || {RspError, RspOp} !== {2'b10, 4'h7}) begin errors++; $display("FAIL div0 got n=%0d err=%b op=%h exp=3/10/7", n, RspError, RspOp); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal;
        bit acc; int n;
        RspReady = 1'b1;
        push(16'd5, 16'd6, 4'h0, 1'b0, acc);
        wait_rsp(10, n);
        checks++; if (n !== 3 || {RspResult, RspError, RspOp} !== {32'd0, 2'b11, 4'h0}) begin errors++; $display("FAIL illegal got n=%0d res=%h err=%b exp=3/0/11", n, RspResult, RspError); end
        @(posedge clk); #1;
        checks++; if (Busy !== 1'b0 || RspValid !== 1'b0) begin errors++; $display("FAIL illegal_idle got busy=%b valid=%b exp=0 0", Busy, RspValid); end
    endtask

    task automatic test_chain;
        bit acc; int n;
        logic [31:0] exp2;
`ifdef ALU_SEQ_CHAIN_EN
        exp2 = 32'd200;
`else
        exp2 = 32'hFFFFFFD5;
`endif
        RspReady = 1'b1;
        push(16'd100, 16'd150, 4'h4, 1'b0, acc);
        push(16'd7, 16'd50, 4'h5, 1'b1, acc);
        wait_rsp(10, n);
        checks++; if (RspValid !== 1'b1 || RspResult !== 32'd250) begin errors++; $display("FAIL chain_first got=%0d exp=250", RspResult); end
        @(posedge clk); #1;
        wait_rsp(10, n);
        checks++; if (n !== 2 || RspResult !== exp2) begin errors++; $display("FAIL chain_second got n=%0d res=%h exp=2/%h", n, RspResult, exp2); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit acc; int n;
        RspReady = 1'b0;
        push(16'd11, 16'd1, 4'h4, 1'b0, acc);
        push(16'd22, 16'd2, 4'h4, 1'b0, acc);
        push(16'd33, 16'd3, 4'h4, 1'b0, acc);
        checks++; if (AluA !== 16'd11 || RspValid !== 1'b0) begin errors++; $display("FAIL rmid_exec got a=%0d valid=%b exp=11 0", AluA, RspValid); end
        rst = 1'b1;
        #1;
        checks++; if ({AluA, AluB, AluOp, RspValid, RspResult, RspError, RspOp, Busy} !== 76'd0 || CmdReady !== 1'b1) begin errors++; $display("FAIL rmid_outputs got=%h ready=%b exp=0 1", {AluA, AluB, AluOp, RspValid, RspResult, RspError, RspOp, Busy}, CmdReady); end
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        RspReady = 1'b1;
        wait_rsp(8, n);
        checks++; if (RspValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp got valid=%b busy=%b exp=0 0", RspValid, Busy); end
        push(16'd1, 16'd2, 4'h4, 1'b0, acc);
        wait_rsp(10, n);
        checks++; if (n !== 3 || RspResult !== 32'd3) begin errors++; $display("FAIL rmid_fresh got n=%0d res=%0d exp=3/3", n, RspResult); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_add;
        test_backpressure;
        test_div_zero;
        test_illegal;
        test_chain;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
